float2fix: RTL and testbench

//  Versat functional unit: 3-stage pipelined IEEE-754 single -> signed fixed-point converter.

---
 rtl/float2fix.sv | 162 ++++++++++++++++
 tb/tb_float2fix.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/float2fix.sv
// float2fix: 3-stage IEEE-754 single to signed fixed-point converter.
// Shadowed runtime config, rounding modes, saturation and event counters.
module float2fix #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              running,
   input  logic              run,
   input  logic [FRAC_W-1:0] frac,
   input  logic [1:0]        rnd,
   input  logic              sat,
   input  logic [31:0]       in0,
   output logic [DATA_W-1:0] out0,
   output logic [CNT_W-1:0]  ovf_cnt,
   output logic [CNT_W-1:0]  nan_cnt
);

   localparam int SHW = (FRAC_W > 8 ? FRAC_W : 8) + 2;
   localparam int WW  = DATA_W + 25;

   localparam logic signed [SHW-1:0] OVF_SH = SHW'(DATA_W - 24);
   localparam logic [DATA_W:0] LIM_N =
      (DATA_W+1)'(1) << (DATA_W - 1);
   localparam logic [DATA_W:0] LIM_P = LIM_N - (DATA_W+1)'(1);
   localparam logic [DATA_W-1:0] INT_MIN =
      {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] INT_MAX = ~INT_MIN;

   typedef struct packed {
      logic           s;
      logic [23:0]    m;
      logic [SHW-1:0] sh;
      logic           nan;
      logic           inf;
      logic [1:0]     rnd;
      logic           sat;
   } s1_t;

   typedef struct packed {
      logic              s;
      logic [DATA_W-1:0] mag;
      logic              g;
      logic              st;
      logic              ovf;
      logic              nan;
      logic [1:0]        rnd;
      logic              sat;
   } s2_t;

   logic [FRAC_W-1:0] cfg_frac;
   logic [1:0]        cfg_rnd;
   logic              cfg_sat;

   s1_t s1, s1_d;
   s2_t s2, s2_d;

   logic [7:0]        e;
   logic [SHW-1:0]    nsh;
   logic [WW-1:0]     mw;
   logic [48:0]       rw;
   logic              inc;
   logic              over;
   logic [DATA_W:0]   magp;
   logic [DATA_W-1:0] res;

   assign e = in0[30:23];

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_frac <= '0;
         cfg_rnd  <= '0;
         cfg_sat  <= 1'b1;
      end else if (run) begin
         cfg_frac <= frac;
         cfg_rnd  <= rnd;
         cfg_sat  <= sat;
      end
   end

   // Config travels with each sample so in-flight data keeps its mode.
   always_comb begin
      s1_d     = '0;
      s1_d.s   = in0[31];
      s1_d.sh  = SHW'(e) - SHW'(150) + SHW'(cfg_frac);
      s1_d.rnd = cfg_rnd;
      s1_d.sat = cfg_sat;
      unique case (1'b1)
         (e == 8'd0): begin
         end
         (e == 8'hff): begin
            s1_d.nan = |in0[22:0];
            s1_d.inf = ~|in0[22:0];
         end
         default: s1_d.m = {1'b1, in0[22:0]};
      endcase
   end

   // Overflow is decided from the shift count, not the shifted value.
   always_comb begin
      s2_d     = '0;
      s2_d.s   = s1.s;
      s2_d.nan = s1.nan;
      s2_d.rnd = s1.rnd;
      s2_d.sat = s1.sat;
      s2_d.ovf = s1.inf |
                 (s1.m[23] & ($signed(s1.sh) > OVF_SH));
      nsh = -s1.sh;
      mw  = WW'(s1.m) << s1.sh;
      rw  = {s1.m, 25'b0} >> nsh;
      if (!s1.sh[SHW-1]) begin
         s2_d.mag = mw[DATA_W-1:0];
      end else if (nsh > SHW'(25)) begin
         s2_d.st = |s1.m;
      end else begin
         s2_d.mag = DATA_W'(rw[48:25]);
         s2_d.g   = rw[24];
         s2_d.st  = |rw[23:0];
      end
   end

   always_comb begin
      inc = 1'b0;
      case (s2.rnd)
         2'd1: inc = s2.g & (s2.st | s2.mag[0]);
         2'd2: inc = s2.s & (s2.g | s2.st);
         2'd3: inc = ~s2.s & (s2.g | s2.st);
         default: inc = 1'b0;
      endcase
      magp = {1'b0, s2.mag} + {{DATA_W{1'b0}}, inc};
      over = s2.ovf | (magp > (s2.s ? LIM_N : LIM_P));
      res  = s2.s ? -magp[DATA_W-1:0] : magp[DATA_W-1:0];
      if (over)
         res = (s2.sat & ~s2.s) ? INT_MAX : INT_MIN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= '0;
         s2      <= '0;
         out0    <= '0;
         ovf_cnt <= '0;
         nan_cnt <= '0;
      end else begin
         s1   <= s1_d;
         s2   <= s2_d;
         out0 <= res;
         if (run) begin
            ovf_cnt <= '0;
            nan_cnt <= '0;
         end else if (running) begin
            if (over && !(&ovf_cnt))
               ovf_cnt <= ovf_cnt + CNT_W'(1);
            if (s2.nan && !(&nan_cnt))
               nan_cnt <= nan_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_float2fix.sv
// tb_float2fix: directed bench for float2fix, DATA_W=32.
// Expected results queue up at drive time and pop three cycles later.
module tb_float2fix;

   logic        clk = 1'b0;
   logic        rst;
   logic        running;
   logic        run;
   logic [5:0]  frac;
   logic [1:0]  rnd;
   logic        sat;
   logic [31:0] in0;
   logic [31:0] out0;
   logic [15:0] ovf_cnt;
   logic [15:0] nan_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          c;
      logic [31:0] e;
      string       tag;
   } exp_t;

   exp_t q[$];

   localparam logic [31:0] F3E9 = 32'h4F32D05E;

   logic [31:0] ramp [8] = '{
      32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
      32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000
   };

   always #5 clk = ~clk;

   float2fix #(
      .DATA_W(32),
      .FRAC_W(6),
      .CNT_W (16)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .running(running),
      .run    (run),
      .frac   (frac),
      .rnd    (rnd),
      .sat    (sat),
      .in0    (in0),
      .out0   (out0),
      .ovf_cnt(ovf_cnt),
      .nan_cnt(nan_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [31:0] f, input bit c,
                      input logic [31:0] e, input string tag,
                      input bit r);
      exp_t x;
      @(negedge clk);
      if (q.size() == 3) begin
         x = q.pop_front();
         if (x.c) check(x.tag, out0, x.e);
      end
      in0 = f;
      run = r;
      q.push_back('{c, e, tag});
   endtask

   task automatic send(input logic [31:0] f, input logic [31:0] e,
                       input string tag);
      cyc(f, 1'b1, e, tag, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(32'h0, 1'b0, 32'h0, "", 1'b0);
   endtask

   task automatic cfg(input logic [5:0] f, input logic [1:0] r,
                      input logic s);
      frac = f;
      rnd  = r;
      sat  = s;
      idle(2);
      cyc(32'h0, 1'b0, 32'h0, "", 1'b1);
      idle(1);
   endtask

   task automatic cnts(input string tag, input logic [15:0] ov,
                       input logic [15:0] nn);
      check({tag, "_ovf"}, 32'(ovf_cnt), 32'(ov));
      check({tag, "_nan"}, 32'(nan_cnt), 32'(nn));
   endtask

   initial begin
      rst     = 1'b1;
      running = 1'b1;
      run     = 1'b0;
      frac    = 6'd0;
      rnd     = 2'd0;
      sat     = 1'b1;
      in0     = 32'h40700000;
      repeat (3) @(negedge clk);
      check("rst_out", out0, 32'h0);
      cnts("rst", 16'd0, 16'd0);
      rst = 1'b0;

      send(32'h40700000, 32'h00000003, "trunc_pos");
      send(32'hC0700000, 32'hFFFFFFFD, "trunc_neg");
      send(32'h80000000, 32'h00000000, "neg_zero");
      send(32'h00400000, 32'h00000000, "denorm");

      cfg(6'd0, 2'd1, 1'b1);
      send(32'h40200000, 32'h00000002, "rne_2p5");
      send(32'h40600000, 32'h00000004, "rne_3p5");
      send(32'hC0200000, 32'hFFFFFFFE, "rne_m2p5");
      cfg(6'd0, 2'd2, 1'b1);
      send(32'hC0200000, 32'hFFFFFFFD, "floor_m2p5");
      cfg(6'd0, 2'd3, 1'b1);
      send(32'h40200000, 32'h00000003, "ceil_2p5");
      cfg(6'd16, 2'd0, 1'b1);
      send(32'h3FC00000, 32'h00018000, "frac16_1p5");
      send(32'h3F800001, 32'h00010000, "frac16_sticky");

      cfg(6'd0, 2'd0, 1'b1);
      cnts("run_clr0", 16'd0, 16'd0);
      send(F3E9, 32'h7FFFFFFF, "sat_pos");
      idle(3);
      cnts("sat_pos", 16'd1, 16'd0);
      send(32'h7F800000, 32'h7FFFFFFF, "inf_pos");
      send(32'h7FC00000, 32'h00000000, "nan");
      send(32'hFF800000, 32'h80000000, "inf_neg");
      idle(3);
      cnts("inf_nan", 16'd3, 16'd1);

      cfg(6'd0, 2'd0, 1'b0);
      cnts("run_clr", 16'd0, 16'd0);
      send(F3E9, 32'h80000000, "nosat_pos");
      send(32'hCF000000, 32'h80000000, "int_min");
      idle(3);
      cnts("nosat", 16'd1, 16'd0);

      running = 1'b0;
      send(F3E9, 32'h80000000, "idle_ovf");
      idle(3);
      cnts("not_running", 16'd1, 16'd0);
      running = 1'b1;

      frac = 6'd16;
      send(32'h3FC00000, 32'h00000001, "frac_no_run");
      idle(3);

      cfg(6'd0, 2'd0, 1'b1);
      for (int i = 0; i < 8; i++)
         send(ramp[i], 32'(i + 1), $sformatf("ramp%0d", i + 1));
      idle(3);

      cfg(6'd16, 2'd3, 1'b0);
      send(F3E9, 32'h80000000, "pre_rst_ovf");
      idle(3);
      cnts("pre_rst", 16'd1, 16'd0);
      for (int i = 0; i < 3; i++)
         cyc(ramp[i], 1'b0, 32'h0, "", 1'b0);
      @(negedge clk);
      rst = 1'b1;
      in0 = 32'h0;
      @(negedge clk);
      check("mid_rst_out", out0, 32'h0);
      cnts("mid_rst", 16'd0, 16'd0);
      rst = 1'b0;
      q.delete();

      send(32'h40700000, 32'h00000003, "cfg_rst_frac");
      send(32'hC0200000, 32'hFFFFFFFE, "cfg_rst_rnd");
      send(F3E9, 32'h7FFFFFFF, "cfg_rst_sat");
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
